// File: rtl/counter_display_driver.sv
// counter_display_driver
//   Display stage for a 5-bit counter value. A load strobe captures the value,
//   a sequential double-dabble engine converts it to two BCD digits, and the
//   result drives a two-digit multiplexed seven-segment display.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n_a   in   asynchronous active-low reset
//   value     in   [4:0] binary value to show (0..31), sampled on accept
//   load      in   sample request, honoured only while idle
//   blank_lz  in   blank the tens digit when it is zero
//   busy      out  conversion in progress
//   seg_n     out  [6:0] segments {g,f,e,d,c,b,a}, active-low
//   an_n      out  [1:0] digit enables, active-low (bit0 ones, bit1 tens)
module counter_display_driver #(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n_a,
  input  logic [4:0] value,
  input  logic       load,
  input  logic       blank_lz,
  output logic       busy,
  output logic [6:0] seg_n,
  output logic [1:0] an_n
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_UPDATE  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [4:0]    shift_q, shift_d;
  logic [7:0]    bcd_q, bcd_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    ones_q, ones_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          sel_q, sel_d;
  logic [6:0]    seg_n_q, seg_n_d;
  logic [1:0]    an_n_q, an_n_d;

  // BCD nibbles after the add-3 correction that precedes every shift.
  logic [7:0]    bcd_adj;
  logic [12:0]   dabble;

  function automatic logic [6:0] seg_lut(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n_a) begin
    if (!rst_n_a) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (load) state_d = S_CONVERT;
      // cnt_q counts completed shifts; the shift taken while it reads 4 is the 5th.
      S_CONVERT: if (cnt_q == 3'd4) state_d = S_UPDATE;
      S_UPDATE:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state_q != S_IDLE);
  end

  // ---------------------------------------------------------------------------
  // Conversion datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    bcd_adj[3:0] = (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];
    bcd_adj[7:4] = (bcd_q[7:4] >= 4'd5) ? bcd_q[7:4] + 4'd3 : bcd_q[7:4];
    dabble       = {bcd_adj, shift_q} << 1;
  end

  always_comb begin
    shift_d = shift_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          shift_d = value;
          bcd_d   = 8'd0;
          cnt_d   = 3'd0;
        end
      end
      S_CONVERT: begin
        bcd_d   = dabble[12:5];
        shift_d = dabble[4:0];
        cnt_d   = cnt_q + 3'd1;
      end
      S_UPDATE: begin
        // Only complete results land here, so the display never shows a
        // half-converted value.
        tens_d = bcd_q[7:4];
        ones_d = bcd_q[3:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n_a) begin
    if (!rst_n_a) begin
      shift_q <= 5'd0;
      bcd_q   <= 8'd0;
      cnt_q   <= 3'd0;
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
    end else begin
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Scan prescaler and digit select
  // ---------------------------------------------------------------------------
  always_comb begin
    presc_d = presc_q + 1'b1;
    sel_d   = sel_q;
    if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      sel_d   = ~sel_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered display drive; an_n and seg_n switch on the same edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    if (!sel_q) begin
      an_n_d  = 2'b10;
      seg_n_d = seg_lut(ones_q);
    end else if (blank_lz && (tens_q == 4'd0)) begin
      an_n_d  = 2'b11;
      seg_n_d = 7'h7F;
    end else begin
      an_n_d  = 2'b01;
      seg_n_d = seg_lut(tens_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n_a) begin
    if (!rst_n_a) begin
      presc_q <= '0;
      sel_q   <= 1'b0;
      seg_n_q <= 7'h7F;
      an_n_q  <= 2'b11;
    end else begin
      presc_q <= presc_d;
      sel_q   <= sel_d;
      seg_n_q <= seg_n_d;
      an_n_q  <= an_n_d;
    end
  end

  assign seg_n = seg_n_q;
  assign an_n  = an_n_q;

endmodule

// File: tb/tb_counter_display_driver.sv
module tb_counter_display_driver;

  logic       clk = 1'b0;
  logic       rst_n_a;
  logic [4:0] value;
  logic       load;
  logic       blank_lz;
  logic       busy;
  logic [6:0] seg_n;
  logic [1:0] an_n;

  int total = 0;
  int bad   = 0;

  counter_display_driver #(.SCAN_DIV(4)) dut (
    .clk      (clk),
    .rst_n_a  (rst_n_a),
    .value    (value),
    .load     (load),
    .blank_lz (blank_lz),
    .busy     (busy),
    .seg_n    (seg_n),
    .an_n     (an_n)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] val;
    logic       blank;
    logic [6:0] tens_seg;
    logic [1:0] tens_an;
    logic [6:0] ones_seg;
  } vec_t;

  vec_t vecs [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  // Pulse load for one edge and measure how long busy stays high.
  task automatic do_load(input logic [4:0] v);
    int n;
    value = v;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    n = 0;
    for (int g = 0; g < 20; g++) begin
      if (!busy) break;
      n++;
      tick();
    end
    $display("load value=%0d busy_cycles=%0d", v, n);
    chk("busy_cycles", 8'(n), 8'd6);
  endtask

  // Observe a full refresh period (both slots) and compare each sample.
  task automatic check_disp(input string name, input logic [6:0] ts, input logic [1:0] ta,
                            input logic [6:0] os);
    logic seen_o, seen_t;
    seen_o = 1'b0;
    seen_t = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      if (an_n == 2'b10) begin
        chk({name, "_ones_seg"}, {1'b0, seg_n}, {1'b0, os});
        seen_o = 1'b1;
      end else begin
        chk({name, "_tens_an"}, {6'd0, an_n}, {6'd0, ta});
        chk({name, "_tens_seg"}, {1'b0, seg_n}, {1'b0, ts});
        seen_t = 1'b1;
      end
      tick();
    end
    chk({name, "_ones_seen"}, {7'd0, seen_o}, 8'd1);
    chk({name, "_tens_seen"}, {7'd0, seen_t}, 8'd1);
    $display("display %s checked", name);
  endtask

  initial begin
    vecs[0] = '{5'd23, 1'b0, 7'h24, 2'b01, 7'h30};
    vecs[1] = '{5'd0,  1'b0, 7'h40, 2'b01, 7'h40};
    vecs[2] = '{5'd9,  1'b0, 7'h40, 2'b01, 7'h10};
    vecs[3] = '{5'd10, 1'b0, 7'h79, 2'b01, 7'h40};
    vecs[4] = '{5'd15, 1'b0, 7'h79, 2'b01, 7'h12};
    vecs[5] = '{5'd31, 1'b0, 7'h30, 2'b01, 7'h79};
    vecs[6] = '{5'd7,  1'b1, 7'h7F, 2'b11, 7'h78};
    vecs[7] = '{5'd0,  1'b1, 7'h7F, 2'b11, 7'h40};
    vecs[8] = '{5'd12, 1'b1, 7'h79, 2'b01, 7'h24};

    rst_n_a  = 1'b0;
    load     = 1'b0;
    value    = 5'd0;
    blank_lz = 1'b0;

    // Reset state, then scan start after release
    #12;
    chk("rst_seg", {1'b0, seg_n}, 8'h7F);
    chk("rst_an", {6'd0, an_n}, 8'h03);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    tick();
    rst_n_a = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("scan_an", {6'd0, an_n}, (i < 4) ? 8'h02 : 8'h01);
      chk("scan_seg", {1'b0, seg_n}, 8'h40);
    end
    $display("reset sequence checked");

    // Table of loads: values, boundaries, blanking
    for (int k = 0; k < 9; k++) begin
      blank_lz = vecs[k].blank;
      do_load(vecs[k].val);
      check_disp($sformatf("vec%0d", k), vecs[k].tens_seg, vecs[k].tens_an, vecs[k].ones_seg);
    end

    // Load while busy: value changes mid-conversion with load held high
    blank_lz = 1'b0;
    value = 5'd5;
    load  = 1'b1;
    tick();                                   // N
    chk("lwb_busy_n", {7'd0, busy}, 8'd1);
    tick();                                   // N+1
    value = 5'd30;
    repeat (5) tick();                        // N+2..N+6
    chk("lwb_busy_n6", {7'd0, busy}, 8'd0);
    tick();                                   // N+7
    chk("lwb_busy_n7", {7'd0, busy}, 8'd1);
    for (int i = 0; i < 7; i++) begin
      if (an_n == 2'b10) chk("lwb_ones05", {1'b0, seg_n}, 8'h12);
      else               chk("lwb_tens05", {1'b0, seg_n}, 8'h40);
      if (i == 6) begin                       // after N+13
        chk("lwb_busy_n13", {7'd0, busy}, 8'd0);
        load = 1'b0;
      end else begin
        tick();
      end
    end
    $display("load-while-busy sequence checked");
    check_disp("lwb30", 7'h30, 2'b01, 7'h40);

    // Reset in the middle of a conversion
    value = 5'd31;
    load  = 1'b1;
    tick();                                   // N
    load  = 1'b0;
    tick();
    tick();                                   // N+2
    #3;
    rst_n_a = 1'b0;
    #1;
    chk("mid_rst_seg", {1'b0, seg_n}, 8'h7F);
    chk("mid_rst_an", {6'd0, an_n}, 8'h03);
    chk("mid_rst_busy", {7'd0, busy}, 8'd0);
    tick();
    tick();
    chk("mid_rst_hold_seg", {1'b0, seg_n}, 8'h7F);
    rst_n_a = 1'b1;
    $display("mid-conversion reset applied");
    check_disp("post_rst", 7'h40, 2'b01, 7'h40);
    chk("post_rst_busy", {7'd0, busy}, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
